// File: rtl/uart_rx_framer_if.sv
// Byte-in / frame-out bundle for uart_rx_framer.
//   master : upstream receiver + downstream consumer side (drives strobe, byte, ready)
//   slave  : the framer (drives frame valid/len/data and error pulses)
// Signals:
//   i_Rx_DV, i_Rx_Byte    byte strobe and data from the UART receiver
//   o_Frame_Valid/Ready   frame handshake
//   o_Frame_Len/Data      payload length and flattened payload (byte k at [8k+7:8k])
//   o_Err_*               one-cycle error pulses
interface uart_rx_framer_if #(
    parameter int unsigned MAX_PAYLOAD = 16
);
    localparam int unsigned LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned DATA_W = 8 * MAX_PAYLOAD;

    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              o_Frame_Valid;
    logic              i_Frame_Ready;
    logic [LEN_W-1:0]  o_Frame_Len;
    logic [DATA_W-1:0] o_Frame_Data;
    logic              o_Err_Length;
    logic              o_Err_Checksum;
    logic              o_Err_Timeout;
    logic              o_Err_Overrun;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Frame_Ready,
        input  o_Frame_Valid, o_Frame_Len, o_Frame_Data,
        input  o_Err_Length, o_Err_Checksum, o_Err_Timeout, o_Err_Overrun
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Frame_Ready,
        output o_Frame_Valid, o_Frame_Len, o_Frame_Data,
        output o_Err_Length, o_Err_Checksum, o_Err_Timeout, o_Err_Overrun
    );
endinterface

// File: rtl/uart_rx_framer.sv
// Assembles sync-prefixed, length-prefixed frames from a UART receiver's byte
// strobe and holds each complete payload behind a valid/ready handshake.
// Wire format: SYNC_BYTE, LEN, LEN payload bytes, [CHK].
// Build option: define UART_RX_FRAMER_CHECKSUM_EN to expect a trailing CHK byte
// such that (LEN + payload + CHK) mod 256 == 0; otherwise frames end on the last
// payload byte and o_Err_Checksum is tied low.
// Ports:
//   i_Clock  clock, all logic on posedge
//   i_Reset  synchronous active-high reset
//   bus      uart_rx_framer_if slave modport (byte input, frame output, error pulses)
module uart_rx_framer #(
    parameter int unsigned MAX_PAYLOAD  = 16,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 1400
) (
    input logic             i_Clock,
    input logic             i_Reset,
    uart_rx_framer_if.slave bus
);
    localparam int unsigned LEN_W  = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned DATA_W = 8 * MAX_PAYLOAD;
    localparam int unsigned TO_W   = $clog2(TIMEOUT_CLKS);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

`ifdef UART_RX_FRAMER_CHECKSUM_EN
    typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_CHECK, S_HOLD} state_t;
`else
    typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              err_len_q, err_len_d;
    logic              err_to_q, err_to_d;
    logic              err_ovr_q, err_ovr_d;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
    logic              err_chk_q, err_chk_d;
`endif
    logic              timing;

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        err_len_d = 1'b0;
        err_to_d  = 1'b0;
        err_ovr_d = 1'b0;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
        sum_d     = sum_q;
        err_chk_d = 1'b0;
`endif
        timing    = 1'b0;

        case (state_q)
            S_SYNC: begin
                if (bus.i_Rx_DV && (bus.i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = S_LEN;
                end
            end

            S_LEN: begin
                timing = 1'b1;
                if (bus.i_Rx_DV) begin
                    if ((bus.i_Rx_Byte == 8'h00) || (32'(bus.i_Rx_Byte) > MAX_PAYLOAD)) begin
                        err_len_d = 1'b1;
                        state_d   = S_SYNC;
                    end else begin
                        len_d   = LEN_W'(bus.i_Rx_Byte);
                        idx_d   = '0;
                        data_d  = '0;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
                        sum_d   = bus.i_Rx_Byte;
`endif
                        state_d = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                timing = 1'b1;
                if (bus.i_Rx_DV) begin
                    for (int unsigned k = 0; k < MAX_PAYLOAD; k++) begin
                        if (idx_q == LEN_W'(k)) begin
                            data_d[8*k +: 8] = bus.i_Rx_Byte;
                        end
                    end
                    idx_d = idx_q + LEN_W'(1);
`ifdef UART_RX_FRAMER_CHECKSUM_EN
                    sum_d = sum_q + bus.i_Rx_Byte;
`endif
                    if (idx_q == (len_q - LEN_W'(1))) begin
`ifdef UART_RX_FRAMER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_HOLD;
                        valid_d = 1'b1;
`endif
                    end
                end
            end

`ifdef UART_RX_FRAMER_CHECKSUM_EN
            S_CHECK: begin
                timing = 1'b1;
                if (bus.i_Rx_DV) begin
                    if (8'(sum_q + bus.i_Rx_Byte) == 8'h00) begin
                        state_d = S_HOLD;
                        valid_d = 1'b1;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = S_SYNC;
                    end
                end
            end
`endif

            S_HOLD: begin
                // A byte here is lost even if the frame is accepted in the same cycle
                if (bus.i_Rx_DV) begin
                    err_ovr_d = 1'b1;
                end
                if (bus.i_Frame_Ready) begin
                    valid_d = 1'b0;
                    state_d = S_SYNC;
                end
            end

            default: begin
                state_d = S_SYNC;
                valid_d = 1'b0;
            end
        endcase

        // Inter-byte watchdog; a strobe in the limit cycle takes priority
        if (timing) begin
            if (bus.i_Rx_DV) begin
                cnt_d = '0;
            end else if (cnt_q == TO_LAST) begin
                cnt_d    = '0;
                err_to_d = 1'b1;
                state_d  = S_SYNC;
            end else begin
                cnt_d = cnt_q + TO_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q   <= S_SYNC;
            len_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            err_len_q <= 1'b0;
            err_to_q  <= 1'b0;
            err_ovr_q <= 1'b0;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
            sum_q     <= '0;
            err_chk_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            err_len_q <= err_len_d;
            err_to_q  <= err_to_d;
            err_ovr_q <= err_ovr_d;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
            sum_q     <= sum_d;
            err_chk_q <= err_chk_d;
`endif
        end
    end

    assign bus.o_Frame_Valid  = valid_q;
    assign bus.o_Frame_Len    = len_q;
    assign bus.o_Frame_Data   = data_q;
    assign bus.o_Err_Length   = err_len_q;
    assign bus.o_Err_Timeout  = err_to_q;
    assign bus.o_Err_Overrun  = err_ovr_q;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
    assign bus.o_Err_Checksum = err_chk_q;
`else
    assign bus.o_Err_Checksum = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_framer.sv
// Testbench for uart_rx_framer: frame-level reference model plus directed
// byte sequences; works with or without UART_RX_FRAMER_CHECKSUM_EN.
module tb_uart_rx_framer;
    localparam int unsigned MAXP   = 16;
    localparam int unsigned TO     = 40;
    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam int unsigned LEN_W  = $clog2(MAXP + 1);
    localparam int unsigned DATA_W = 8 * MAXP;
`ifdef UART_RX_FRAMER_CHECKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_rx_framer_if #(.MAX_PAYLOAD(MAXP)) bus ();

    uart_rx_framer #(
        .MAX_PAYLOAD (MAXP),
        .SYNC_BYTE   (SYNC),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: bytes after sync are collected in a queue and the
    // frame is judged once the queue holds LEN + payload (+ CHK).
    bit                in_frame  = 1'b0;
    bit                held      = 1'b0;
    bit                chk_data  = 1'b0;
    logic [7:0]        fb[$];
    int                idle      = 0;
    int                flen      = 0;
    int                fsum      = 0;
    logic              exp_valid = 1'b0;
    logic              exp_el    = 1'b0;
    logic              exp_ec    = 1'b0;
    logic              exp_et    = 1'b0;
    logic              exp_eo    = 1'b0;
    logic [LEN_W-1:0]  exp_len   = '0;
    logic [DATA_W-1:0] exp_data  = '0;

    always @(posedge clk) begin
        exp_el   = 1'b0;
        exp_ec   = 1'b0;
        exp_et   = 1'b0;
        exp_eo   = 1'b0;
        chk_data = 1'b0;
        if (rst) begin
            in_frame  = 1'b0;
            held      = 1'b0;
            fb.delete();
            idle      = 0;
            exp_valid = 1'b0;
            exp_len   = '0;
            exp_data  = '0;
            chk_data  = 1'b1;
        end else if (held) begin
            if (bus.i_Rx_DV) exp_eo = 1'b1;
            if (bus.i_Frame_Ready) begin
                held      = 1'b0;
                exp_valid = 1'b0;
            end
        end else if (!in_frame) begin
            if (bus.i_Rx_DV && bus.i_Rx_Byte == SYNC) begin
                in_frame = 1'b1;
                fb.delete();
                idle = 0;
            end
        end else if (bus.i_Rx_DV) begin
            idle = 0;
            fb.push_back(bus.i_Rx_Byte);
            flen = int'(fb[0]);
            if (fb.size() == 1) begin
                if (flen == 0 || flen > int'(MAXP)) begin
                    exp_el   = 1'b1;
                    in_frame = 1'b0;
                end
            end else if (fb.size() == 1 + flen + CHK) begin
                in_frame = 1'b0;
                fsum = 0;
                foreach (fb[i]) fsum += int'(fb[i]);
                if (CHK == 1 && (fsum % 256) != 0) begin
                    exp_ec = 1'b1;
                end else begin
                    held      = 1'b1;
                    exp_valid = 1'b1;
                    exp_len   = LEN_W'(flen);
                    exp_data  = '0;
                    for (int i = 0; i < flen; i++) exp_data[8*i +: 8] = fb[i+1];
                end
            end
        end else begin
            idle++;
            if (idle == int'(TO)) begin
                exp_et   = 1'b1;
                in_frame = 1'b0;
            end
        end
    end

    int seen_el = 0;
    int seen_ec = 0;
    int seen_et = 0;
    int seen_eo = 0;

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("valid",     DATA_W'(bus.o_Frame_Valid),  DATA_W'(exp_valid));
        check("err_len",   DATA_W'(bus.o_Err_Length),   DATA_W'(exp_el));
        check("err_chk",   DATA_W'(bus.o_Err_Checksum), DATA_W'(exp_ec));
        check("err_to",    DATA_W'(bus.o_Err_Timeout),  DATA_W'(exp_et));
        check("err_ovr",   DATA_W'(bus.o_Err_Overrun),  DATA_W'(exp_eo));
        if (exp_valid || chk_data) begin
            check("len",  DATA_W'(bus.o_Frame_Len), DATA_W'(exp_len));
            check("data", bus.o_Frame_Data, exp_data);
        end
        if (bus.o_Err_Length === 1'b1)   seen_el++;
        if (bus.o_Err_Checksum === 1'b1) seen_ec++;
        if (bus.o_Err_Timeout === 1'b1)  seen_et++;
        if (bus.o_Err_Overrun === 1'b1)  seen_eo++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        tick();
        bus.i_Rx_DV   = 1'b0;
        tick();
    endtask

    // Trailing checksum byte, only on the wire when the checksum build is active
    task automatic send_chk(input logic [7:0] b);
`ifdef UART_RX_FRAMER_CHECKSUM_EN
        send(b);
`else
        bus.i_Rx_Byte = b;
`endif
    endtask

    task automatic accept();
        bus.i_Frame_Ready = 1'b1;
        tick();
        bus.i_Frame_Ready = 1'b0;
        check("lit_valid_after_accept", DATA_W'(bus.o_Frame_Valid), DATA_W'(0));
    endtask

    initial begin
        bus.i_Rx_DV       = 1'b0;
        bus.i_Rx_Byte     = 8'h00;
        bus.i_Frame_Ready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        check("lit_rst_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(0));
        check("lit_rst_len",   DATA_W'(bus.o_Frame_Len),   DATA_W'(0));
        check("lit_rst_data",  bus.o_Frame_Data,           DATA_W'(0));
        rst = 1'b0;
        tick();

        // Basic frame
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send_chk(8'h97);
        check("lit_f1_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(1));
        check("lit_f1_len",   DATA_W'(bus.o_Frame_Len),   DATA_W'(3));
        check("lit_f1_data",  bus.o_Frame_Data,           DATA_W'(24'h332211));
        accept();

`ifdef UART_RX_FRAMER_CHECKSUM_EN
        // Bad checksum
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h98);
        check("lit_chk_err_count", DATA_W'(seen_ec),           DATA_W'(1));
        check("lit_chk_err_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(0));
`endif
        // Payload containing the sync value
        send(8'hA5); send(8'h01); send(8'h5A); send_chk(8'hA5);
        check("lit_f2_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(1));
        check("lit_f2_len",   DATA_W'(bus.o_Frame_Len),   DATA_W'(1));
        check("lit_f2_data",  bus.o_Frame_Data,           DATA_W'(8'h5A));
        accept();

        // Garbage then length errors
        send(8'h00); send(8'hFF); send(8'hA5); send(8'h00);
        check("lit_len0", DATA_W'(seen_el), DATA_W'(1));
        send(8'hA5); send(8'h11);
        check("lit_len17", DATA_W'(seen_el), DATA_W'(2));

        // Timeout
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (TO) tick();
        check("lit_timeout", DATA_W'(seen_et), DATA_W'(1));

        // Strobe in the exact limit cycle is taken as data
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (TO - 2) tick();
        send(8'h20); send_chk(8'hCE);
        check("lit_to_edge_count", DATA_W'(seen_et),           DATA_W'(1));
        check("lit_to_edge_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(1));
        check("lit_to_edge_data",  bus.o_Frame_Data,           DATA_W'(16'h2010));
        accept();

        // Overrun while held, then overrun with same-cycle accept
        send(8'hA5); send(8'h01); send(8'h42); send_chk(8'hBD);
        send(8'h77);
        check("lit_ovr_count", DATA_W'(seen_eo),           DATA_W'(1));
        check("lit_ovr_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(1));
        check("lit_ovr_data",  bus.o_Frame_Data,           DATA_W'(8'h42));
        bus.i_Rx_DV       = 1'b1;
        bus.i_Rx_Byte     = 8'h88;
        bus.i_Frame_Ready = 1'b1;
        tick();
        bus.i_Rx_DV       = 1'b0;
        bus.i_Frame_Ready = 1'b0;
        check("lit_ovr_acc_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(0));
        // Sync arrives the cycle right after acceptance
        send(8'hA5); send(8'h01); send(8'h42); send_chk(8'hBD);
        check("lit_b2b_ovr",   DATA_W'(seen_eo),           DATA_W'(2));
        check("lit_b2b_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(1));
        accept();

        // Reset mid-payload
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        rst = 1'b1;
        tick();
        check("lit_mid_rst_len",  DATA_W'(bus.o_Frame_Len), DATA_W'(0));
        check("lit_mid_rst_data", bus.o_Frame_Data,          DATA_W'(0));
        rst = 1'b0;
        tick();
        send(8'hA5); send(8'h02); send(8'hAB); send(8'hCD); send_chk(8'h86);
        check("lit_f3_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(1));
        check("lit_f3_len",   DATA_W'(bus.o_Frame_Len),   DATA_W'(2));
        check("lit_f3_data",  bus.o_Frame_Data,           DATA_W'(16'hCDAB));

        // Reset while holding drops the frame
        rst = 1'b1;
        tick();
        check("lit_hold_rst_valid", DATA_W'(bus.o_Frame_Valid), DATA_W'(0));
        rst = 1'b0;
        tick();

        check("lit_total_len",  DATA_W'(seen_el), DATA_W'(2));
        check("lit_total_chk",  DATA_W'(seen_ec), DATA_W'(CHK));
        check("lit_total_to",   DATA_W'(seen_et), DATA_W'(1));
        check("lit_total_ovr",  DATA_W'(seen_eo), DATA_W'(2));

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
